// File: rtl/mux_scan_ctrl.sv
// Scans an external NSEL:1 mux one select code per cycle and packs the returned bits
// into a word handed to the consumer over a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int NSEL = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            mux_out,
    input  logic            ready,
    output logic            c1,
    output logic            c2,
    output logic            c3,
    output logic            c4,
    output logic            busy,
    output logic [NSEL-1:0] data,
    output logic            valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NSEL - 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [NSEL-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              rst_sync_q, rst_sync_d;

    // Release flop: constant one shifted in after reset, gating the datapath for one edge.
    always_comb begin
        rst_sync_d = 1'b1;
    end

    // Reset-release synchroniser (asserts asynchronously, releases on the first edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // State register; held in IDLE until the release flop has seen rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (rst_sync_q) begin
            state_q <= state_d;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (valid_q && ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: select index, captured word and valid flag.
    always_comb begin
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = 4'd0;
                    data_d  = {NSEL{1'b0}};
                    valid_d = 1'b0;
                end else begin
                    idx_d   = 4'd0;
                    valid_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    idx_d   = 4'd0;
                    valid_d = 1'b0;
                end else begin
                    // The mux is combinational: the bit for idx_q is present in this cycle.
                    for (int k = 0; k < NSEL; k++) begin
                        if (idx_q == 4'(k)) begin
                            data_d[k] = mux_out;
                        end else begin
                            data_d[k] = data_q[k];
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        valid_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                idx_d = 4'd0;
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                idx_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 4'd0;
            data_q  <= {NSEL{1'b0}};
            valid_q <= 1'b0;
        end else if (rst_sync_q) begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end else begin
            idx_q   <= 4'd0;
            data_q  <= {NSEL{1'b0}};
            valid_q <= 1'b0;
        end
    end

    assign c1    = idx_q[3];
    assign c2    = idx_q[2];
    assign c3    = idx_q[1];
    assign c4    = idx_q[0];
    assign busy  = (state_q == ST_SCAN);
    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter NSEL, default 10, meaning the number of mux inputs scanned; the legal range is 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of a scan in progress.
REQ-006 SHALL have port mux_out, input, 1 bit: the selected bit returned by the downstream 10:1 mux.
REQ-007 SHALL have ports c1, c2, c3, c4, output, 1 bit each: the mux select code; c1 is the MSB, c4 the LSB; index k selects input k (0 = a ... 9 = j).
REQ-008 SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-009 SHALL have port data, output, NSEL bits: captured word; bit k = mux_out sampled while index k was driven.
REQ-010 SHALL have port valid, output, 1 bit: data is complete and stable.
REQ-011 SHALL have port ready, input, 1 bit: the consumer accepts data when valid && ready.

Function
REQ-012 SHALL implement the states IDLE, SCAN and DONE, held in a registered state machine.
REQ-013 In IDLE, start=1 at a rising edge SHALL move the machine to SCAN, set idx to 0 and clear data to 0.
REQ-014 In SCAN, each rising edge SHALL write mux_out into data[idx]; if idx < NSEL-1, idx SHALL increment by 1.
REQ-015 In SCAN, the edge that samples idx = NSEL-1 SHALL move the machine to DONE, set valid to 1 and return idx to 0.
REQ-016 c1..c4 SHALL be driven directly from the idx register, with no combinational path from any input; they SHALL be 0000 in IDLE and DONE.
REQ-017 The latency from the start-accept edge to valid=1 SHALL be exactly NSEL rising edges; busy SHALL be high for exactly NSEL cycles.
REQ-018 The mux is combinational, so mux_out SHALL be sampled on the same edge that ends the cycle in which its select code was driven.
REQ-019 In DONE, data and valid SHALL hold until valid && ready, which SHALL return the machine to IDLE with valid=0 and data unchanged.
REQ-020 ready SHALL be ignored outside DONE.
REQ-021 start SHALL be ignored in SCAN and DONE; no queuing.
REQ-022 A start asserted on the same edge that consumes the handshake in DONE SHALL be ignored; a new scan SHALL require start while in IDLE.
REQ-023 abort=1 in SCAN SHALL return the machine to IDLE with idx=0 and valid=0; the partial data SHALL be retained but SHALL never be flagged valid.
REQ-024 abort SHALL have no effect in IDLE or DONE.
REQ-025 If abort and start are both high in IDLE, start SHALL be taken.
REQ-026 idx SHALL never exceed NSEL-1; select codes NSEL..15 SHALL never be driven.
REQ-027 data bits at or above NSEL do not exist; the width of data SHALL be exactly NSEL.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, idx=0, c1..c4=0000, data=0, busy=0 and valid=0.
REQ-029 Deassertion of rst_n SHALL be synchronised to clk; the first operative edge SHALL be the second rising edge after rst_n rises.
REQ-030 Reset asserted during SCAN or DONE SHALL discard the operation; no valid pulse SHALL follow.

Verification
REQ-031 The bench SHALL cover: mux inputs a..j = 1,0,1,1,0,0,1,0,1,1, start pulse -> c1..c4 steps 0000..1001 one per cycle, valid after 10 edges, data=10'b1101001101 (bit0=a), ready=1 -> IDLE.
REQ-032 The bench SHALL cover: same scan with ready held 0 for 5 cycles after valid -> valid and data stable throughout, c1..c4=0000, busy=0; ready=1 -> valid=0 on the next edge.
REQ-033 The bench SHALL cover: abort at idx=4 -> busy=0 next cycle, valid never rises; a following start gives a full 10-cycle scan with correct data.
REQ-034 The bench SHALL cover: start repeated every cycle during SCAN and DONE -> exactly one scan, and no rescan on the handshake edge.
REQ-035 The bench SHALL cover: rst_n low mid-SCAN at idx=6 -> outputs 0 asynchronously, before the next edge; after release the bench idles until start.
REQ-036 The bench SHALL cover: NSEL=2 -> select codes 0000 then 0001, valid after 2 edges, data={b,a}.
